// File: rtl/i2s_tx_serializer.sv
// I2S master transmitter: one-pair holding buffer feeding a Philips-format serializer.
// SCK/WS/SD are generated from clk and are all registered.
module i2s_tx_serializer #(
   parameter int DATA_W  = 24,
   parameter int SLOT_W  = 32,
   parameter int CLK_DIV = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              enable,
   input  logic [DATA_W-1:0] left_data,
   input  logic [DATA_W-1:0] right_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              i2s_sck,
   output logic              i2s_ws,
   output logic              i2s_sd,
   output logic              frame_start,
   output logic              underrun,
   output logic [15:0]       underrun_cnt
);

   localparam int FRAME_BITS = 2 * SLOT_W;
   localparam int BIT_W      = $clog2(FRAME_BITS);
   localparam int DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
   localparam logic [BIT_W-1:0] LAST_B   = BIT_W'(FRAME_BITS - 1);
   localparam logic [BIT_W-1:0] SLOT_B   = BIT_W'(SLOT_W);
   localparam logic [BIT_W-1:0] L_LAST   = BIT_W'(DATA_W);
   localparam logic [BIT_W-1:0] R_FIRST  = BIT_W'(SLOT_W + 1);
   localparam logic [BIT_W-1:0] R_LAST   = BIT_W'(SLOT_W + DATA_W);

   typedef enum logic {ST_IDLE, ST_RUN} state_t;

   state_t              state_reg, state_next;
   logic [DIV_W-1:0]    div_reg, div_next;
   logic [BIT_W-1:0]    bit_reg, bit_next;
   logic                sck_reg, sck_next;
   logic                ws_reg, ws_next;
   logic                sd_reg, sd_next;
   logic [DATA_W-1:0]   left_sr_reg, left_sr_next;
   logic [DATA_W-1:0]   right_sr_reg, right_sr_next;
   logic [DATA_W-1:0]   buf_left_reg, buf_left_next;
   logic [DATA_W-1:0]   buf_right_reg, buf_right_next;
   logic                buf_full_reg, buf_full_next;
   logic                frame_start_reg, frame_start_next;
   logic                underrun_reg, underrun_next;
   logic [15:0]         underrun_cnt_reg, underrun_cnt_next;

   logic                div_tc;
   logic                fall_tick;
   logic                load;
   logic                write;
   logic [BIT_W-1:0]    bit_inc;

   assign div_tc    = (div_reg == DIV_LAST);
   assign fall_tick = (state_reg == ST_RUN) && enable && div_tc && sck_reg;
   assign bit_inc   = (bit_reg == LAST_B) ? '0 : bit_reg + BIT_ONE;
   assign load      = ((state_reg == ST_IDLE) && enable) || (fall_tick && (bit_reg == LAST_B));
   assign write     = in_valid && !buf_full_reg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_reg <= ST_IDLE;
      else          state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (enable)  state_next = ST_RUN;
         ST_RUN:  if (!enable) state_next = ST_IDLE;
         default:              state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      div_next          = div_reg;
      bit_next          = bit_reg;
      sck_next          = sck_reg;
      ws_next           = ws_reg;
      sd_next           = sd_reg;
      left_sr_next      = left_sr_reg;
      right_sr_next     = right_sr_reg;
      buf_left_next     = buf_left_reg;
      buf_right_next    = buf_right_reg;
      buf_full_next     = buf_full_reg;
      frame_start_next  = 1'b0;
      underrun_next     = 1'b0;
      underrun_cnt_next = underrun_cnt_reg;

      // A write into an empty buffer always lands, even on a load clk (no bypass).
      if (write) begin
         buf_left_next  = left_data;
         buf_right_next = right_data;
         buf_full_next  = 1'b1;
      end else if (load) begin
         buf_full_next  = 1'b0;
      end

      if ((state_reg == ST_IDLE) || !enable) begin
         div_next = '0;
         bit_next = '0;
         sck_next = 1'b0;
         ws_next  = 1'b0;
         sd_next  = 1'b0;
      end else if (div_tc) begin
         div_next = '0;
         sck_next = !sck_reg;
         if (sck_reg) begin
            bit_next = bit_inc;
            ws_next  = (bit_inc >= SLOT_B);
            if ((bit_inc >= BIT_ONE) && (bit_inc <= L_LAST)) begin
               sd_next      = left_sr_reg[DATA_W-1];
               left_sr_next = left_sr_reg << 1;
            end else if ((bit_inc >= R_FIRST) && (bit_inc <= R_LAST)) begin
               sd_next       = right_sr_reg[DATA_W-1];
               right_sr_next = right_sr_reg << 1;
            end else begin
               sd_next = 1'b0;
            end
         end
      end else begin
         div_next = div_reg + DIV_W'(1);
      end

      if (load) begin
         left_sr_next     = buf_full_reg ? buf_left_reg  : '0;
         right_sr_next    = buf_full_reg ? buf_right_reg : '0;
         frame_start_next = 1'b1;
         underrun_next    = !buf_full_reg;
         if (!buf_full_reg && (underrun_cnt_reg != 16'hFFFF))
            underrun_cnt_next = underrun_cnt_reg + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_reg          <= '0;
         bit_reg          <= '0;
         sck_reg          <= 1'b0;
         ws_reg           <= 1'b0;
         sd_reg           <= 1'b0;
         left_sr_reg      <= '0;
         right_sr_reg     <= '0;
         buf_left_reg     <= '0;
         buf_right_reg    <= '0;
         buf_full_reg     <= 1'b0;
         frame_start_reg  <= 1'b0;
         underrun_reg     <= 1'b0;
         underrun_cnt_reg <= '0;
      end else begin
         div_reg          <= div_next;
         bit_reg          <= bit_next;
         sck_reg          <= sck_next;
         ws_reg           <= ws_next;
         sd_reg           <= sd_next;
         left_sr_reg      <= left_sr_next;
         right_sr_reg     <= right_sr_next;
         buf_left_reg     <= buf_left_next;
         buf_right_reg    <= buf_right_next;
         buf_full_reg     <= buf_full_next;
         frame_start_reg  <= frame_start_next;
         underrun_reg     <= underrun_next;
         underrun_cnt_reg <= underrun_cnt_next;
      end
   end

   assign in_ready     = !buf_full_reg;
   assign i2s_sck      = sck_reg;
   assign i2s_ws       = ws_reg;
   assign i2s_sd       = sd_reg;
   assign frame_start  = frame_start_reg;
   assign underrun     = underrun_reg;
   assign underrun_cnt = underrun_cnt_reg;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Bench for i2s_tx_serializer: an SCK-rising-edge receiver rebuilds each frame and compares it
// with a frame computed from the I2S bit-placement rules and a queue of accepted sample pairs.
module tb_i2s_tx_serializer;

   localparam int DW = 24;
   localparam int SW = 32;
   localparam int CD = 2;
   localparam int FB = 2 * SW;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          enable;
   logic [DW-1:0] in_l, in_r;
   logic          in_valid;
   logic          in_ready;
   logic          i2s_sck, i2s_ws, i2s_sd;
   logic          frame_start, underrun;
   logic [15:0]   underrun_cnt;

   i2s_tx_serializer #(.DATA_W(DW), .SLOT_W(SW), .CLK_DIV(CD)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .enable       (enable),
      .left_data    (in_l),
      .right_data   (in_r),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .i2s_sck      (i2s_sck),
      .i2s_ws       (i2s_ws),
      .i2s_sd       (i2s_sd),
      .frame_start  (frame_start),
      .underrun     (underrun),
      .underrun_cnt (underrun_cnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [DW-1:0] l;
      logic [DW-1:0] r;
      int            cap;
   } pair_t;

   pair_t         q[$];
   int            vectors = 0;
   int            miscompares = 0;
   int            exp_cnt = 0;
   int            bit_idx = -1;
   int            fs_cyc = 0;
   int            rise0_cyc = 0;
   int            last_fs = -1;
   int            frames_checked = 0;
   int            frame_acc = 0;
   bit            stream = 1'b0;
   bit            acc_pend = 1'b0;
   logic          prev_sck = 1'b0;
   logic          exp_ur;
   logic [DW-1:0] exp_l, exp_r;
   logic [FB-1:0] sd_cap, ws_cap;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected serial word, bit b of the result = SD during frame bit b.
   function automatic logic [FB-1:0] frame_sd(input logic [DW-1:0] l, input logic [DW-1:0] r);
      logic [FB-1:0] w = '0;
      for (int b = 0; b < FB; b++) begin
         if (b >= 1 && b <= DW)                w[b] = l[DW - b];
         else if (b >= SW + 1 && b <= SW + DW) w[b] = r[DW - (b - SW)];
      end
      return w;
   endfunction

   function automatic logic [FB-1:0] frame_ws();
      logic [FB-1:0] w = '0;
      for (int b = SW; b < FB; b++) w[b] = 1'b1;
      return w;
   endfunction

   task automatic record();
      pair_t p;
      p.l = in_l; p.r = in_r; p.cap = cyc + 1;
      q.push_back(p);
      acc_pend = 1'b1;
      frame_acc++;
   endtask

   task automatic offer(input logic [DW-1:0] l, input logic [DW-1:0] r);
      in_l = l; in_r = r; in_valid = 1'b1;
      if (in_ready) record();
   endtask

   task automatic step();
      @(negedge clk);
      if (frame_start) begin
         if (q.size() > 0 && q[0].cap < cyc) begin
            pair_t p = q.pop_front();
            exp_l = p.l; exp_r = p.r; exp_ur = 1'b0;
         end else begin
            exp_l = '0; exp_r = '0; exp_ur = 1'b1;
            if (exp_cnt < 65535) exp_cnt++;
         end
         chk("underrun_pulse", 64'(underrun), 64'(exp_ur));
         chk("underrun_cnt", 64'(underrun_cnt), 64'(exp_cnt));
         if (last_fs >= 0) chk("frame_period", 64'(cyc - last_fs), 64'(2 * FB * CD));
         if (stream) chk("accepts_per_frame", 64'(frame_acc), 64'd1);
         frame_acc = 0;
         last_fs = cyc;
         fs_cyc = cyc;
         bit_idx = 0;
      end
      if (i2s_sck && !prev_sck && bit_idx >= 0) begin
         sd_cap[bit_idx] = i2s_sd;
         ws_cap[bit_idx] = i2s_ws;
         if (bit_idx == 0) begin
            chk("first_rise_delay", 64'(cyc - fs_cyc), 64'(CD));
            rise0_cyc = cyc;
         end else if (bit_idx == 1) begin
            chk("sck_period", 64'(cyc - rise0_cyc), 64'(2 * CD));
         end
         if (stream && frame_acc == 1) chk("ready_low_while_full", 64'(in_ready), 64'd0);
         bit_idx++;
         if (bit_idx == FB) begin
            chk("frame_sd", 64'(sd_cap), 64'(frame_sd(exp_l, exp_r)));
            chk("frame_ws", 64'(ws_cap), 64'(frame_ws()));
            frames_checked++;
            bit_idx = -1;
         end
      end
      prev_sck = i2s_sck;
      if (acc_pend) begin
         acc_pend = 1'b0;
         if (stream) begin
            in_l = DW'($urandom);
            in_r = DW'($urandom);
         end else begin
            in_valid = 1'b0;
         end
      end
      if (in_valid && in_ready) record();
   endtask

   task automatic run_frames(input int n);
      int target = frames_checked + n;
      for (int i = 0; i < n * 300 + 300 && frames_checked < target; i++) step();
      if (frames_checked < target) chk("frame_timeout", 64'(frames_checked), 64'(target));
   endtask

   task automatic run_until_bit(input int k);
      int n = 0;
      do begin
         step();
         n++;
      end while (bit_idx != k && n < 700);
      if (bit_idx != k) chk("bit_timeout", 64'(bit_idx), 64'(k));
   endtask

   initial begin
      reset_n = 1'b0; enable = 1'b0; in_valid = 1'b0; in_l = '0; in_r = '0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("rst_sck", 64'(i2s_sck), 64'd0);
      chk("rst_ws", 64'(i2s_ws), 64'd0);
      chk("rst_sd", 64'(i2s_sd), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_underrun_cnt", 64'(underrun_cnt), 64'd0);
      chk("rst_frame_start", 64'(frame_start), 64'd0);

      // Known pattern, then the underrun frame with a mid-frame write, then its playback.
      offer(24'hA5A5A5, 24'h5A5A5A);
      step();
      chk("ready_after_write", 64'(in_ready), 64'd0);
      enable = 1'b1;
      run_frames(1);
      run_until_bit(20);
      offer(DW'($urandom), DW'($urandom));
      run_frames(2);

      // Continuous stream: one pair per frame, none dropped or duplicated.
      run_until_bit(2);
      stream = 1'b1;
      frame_acc = 0;
      offer(DW'($urandom), DW'($urandom));
      run_frames(9);
      stream = 1'b0;
      in_valid = 1'b0;

      // Stop mid-frame in the right slot, then restart with the retained pair.
      run_until_bit(10);
      offer(DW'($urandom), DW'($urandom));
      step();
      run_until_bit(41);
      enable = 1'b0;
      bit_idx = -1;
      last_fs = -1;
      step();
      chk("stop_sck", 64'(i2s_sck), 64'd0);
      chk("stop_ws", 64'(i2s_ws), 64'd0);
      chk("stop_sd", 64'(i2s_sd), 64'd0);
      repeat (7) step();
      chk("stop_buffer_kept", 64'(in_ready), 64'd0);
      enable = 1'b1;
      run_frames(1);

      // Asynchronous reset in the middle of a frame with the buffer full.
      run_until_bit(5);
      offer(DW'($urandom), DW'($urandom));
      step();
      run_until_bit(45);
      #2 reset_n = 1'b0;
      #1;
      chk("arst_sck", 64'(i2s_sck), 64'd0);
      chk("arst_ws", 64'(i2s_ws), 64'd0);
      chk("arst_sd", 64'(i2s_sd), 64'd0);
      chk("arst_in_ready", 64'(in_ready), 64'd1);
      chk("arst_underrun_cnt", 64'(underrun_cnt), 64'd0);
      q.delete();
      exp_cnt = 0; bit_idx = -1; last_fs = -1; acc_pend = 1'b0;
      enable = 1'b0; in_valid = 1'b0; prev_sck = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      enable = 1'b1;
      run_frames(1);
      enable = 1'b0;
      step();

      // Short enable pulses: each IDLE->RUN entry is a load with an empty buffer.
      for (int i = 0; i < 70000; i++) begin
         enable = 1'b1;
         @(negedge clk);
         if (exp_cnt < 65535) exp_cnt++;
         if ((i >= 65531 && i <= 65535) || i == 69999) begin
            chk("sat_cnt", 64'(underrun_cnt), 64'(exp_cnt));
            chk("sat_underrun", 64'(underrun), 64'd1);
         end
         enable = 1'b0;
         @(negedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
